// File: rtl/pcie_bridge_pkg.sv
// pcie_bridge_pkg
// Shared definitions for the PCIe memory request bridge:
//   - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - TIMEOUT_RDATA, the read data returned when a timed-out read is answered
//   - layout of a queued command entry, {write, addr, wdata}, and its width
package pcie_bridge_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_WAIT  = 2'd2;
    localparam logic [1:0] STATE_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_ISSUE = STATE_ISSUE,
        ST_WAIT  = STATE_WAIT,
        ST_RESP  = STATE_RESP
    } bridge_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // A command entry is packed as {write, addr, wdata}, write in the MSB.
    function automatic int cmd_entry_width(input int addr_width, input int data_width);
        return 1 + addr_width + data_width;
    endfunction

endpackage

// File: rtl/pcie_cmd_fifo.sv
// pcie_cmd_fifo
// Synchronous FIFO holding host commands for the bridge.
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   push, push_data    write an entry (ignored when full)
//   pop                discard the head entry (ignored when empty)
//   head               current head entry
//   full, empty        status derived from the registered pointers
module pcie_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 49
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    // One extra pointer bit tells a full FIFO apart from an empty one.
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
    assign head  = mem[rd_ptr[PTR_WIDTH-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pcie_mem_req_bridge.sv
// pcie_mem_req_bridge
// Accepts host read/write commands, queues them, issues them one at a time
// on the wrapper's level-held request / pulsed ready port pairs, and returns
// one in-order response per command.
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            host command stream (cmd_write, cmd_addr, cmd_wdata)
//   resp_valid/resp_ready          response stream (resp_write, resp_error, resp_rdata)
//   pcie_read_request/addr         downstream read, completed by pcie_read_ready + pcie_read_data
//   pcie_write_request/addr/data   downstream write, completed by pcie_write_ready
// Optional feature macro: PCIE_BRIDGE_TIMEOUT_EN adds a WAIT timeout that
// answers with resp_error=1; without it resp_error is tied to 0.
module pcie_mem_req_bridge
    import pcie_bridge_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [MEM_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_write,
    output logic                      resp_error,
    output logic [MEM_DATA_WIDTH-1:0] resp_rdata,
    output logic                      pcie_read_request,
    output logic [MEM_ADDR_WIDTH-1:0] pcie_read_addr,
    input  logic                      pcie_read_ready,
    input  logic [MEM_DATA_WIDTH-1:0] pcie_read_data,
    output logic                      pcie_write_request,
    output logic [MEM_ADDR_WIDTH-1:0] pcie_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] pcie_write_data,
    input  logic                      pcie_write_ready
);

    localparam int ENTRY_WIDTH = cmd_entry_width(MEM_ADDR_WIDTH, MEM_DATA_WIDTH);

    bridge_state_t state;
    bridge_state_t state_next;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [ENTRY_WIDTH-1:0]    fifo_head;

    logic                      cmd_reg_write;
    logic [MEM_ADDR_WIDTH-1:0] cmd_reg_addr;
    logic [MEM_DATA_WIDTH-1:0] cmd_reg_wdata;

    logic                      resp_write_reg;
    logic [MEM_DATA_WIDTH-1:0] resp_rdata_reg;

    logic                      ready_match;
    logic                      capture;
    logic [MEM_DATA_WIDTH-1:0] capture_rdata;

    // cmd_ready looks only at the registered full flag, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

    pcie_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_cmd_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_write, cmd_addr, cmd_wdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Only the ready of the kind matching the in-flight command completes it.
    assign ready_match = cmd_reg_write ? pcie_write_ready : pcie_read_ready;

`ifdef PCIE_BRIDGE_TIMEOUT_EN
    localparam int                      COUNT_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [MEM_DATA_WIDTH-1:0] TIMEOUT_FILL = MEM_DATA_WIDTH'(TIMEOUT_RDATA);

    logic [COUNT_WIDTH-1:0] wait_count;
    logic                   timed_out;
    logic                   capture_error;
    logic                   resp_error_reg;

    assign timed_out  = (wait_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign resp_error = resp_error_reg;

    // Counter restarts as the FSM enters WAIT and advances every WAIT cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_count     <= '0;
            resp_error_reg <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_count <= '0;
            end else if (state == ST_WAIT) begin
                wait_count <= wait_count + 1'b1;
            end
            if (capture) begin
                resp_error_reg <= capture_error;
            end
        end
    end
`else
    assign resp_error = 1'b0;
`endif

    // Next-state and response capture. A matching ready beats an expiring
    // timeout in the same cycle.
    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        capture_rdata = '0;
`ifdef PCIE_BRIDGE_TIMEOUT_EN
        capture_error = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_match) begin
                    state_next    = ST_RESP;
                    capture       = 1'b1;
                    capture_rdata = cmd_reg_write ? '0 : pcie_read_data;
                end
`ifdef PCIE_BRIDGE_TIMEOUT_EN
                else if (timed_out) begin
                    state_next    = ST_RESP;
                    capture       = 1'b1;
                    capture_error = 1'b1;
                    capture_rdata = cmd_reg_write ? '0 : TIMEOUT_FILL;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cmd_reg_write  <= 1'b0;
            cmd_reg_addr   <= '0;
            cmd_reg_wdata  <= '0;
            resp_write_reg <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            state <= state_next;
            if (fifo_pop) begin
                cmd_reg_write <= fifo_head[ENTRY_WIDTH-1];
                cmd_reg_addr  <= fifo_head[MEM_DATA_WIDTH +: MEM_ADDR_WIDTH];
                cmd_reg_wdata <= fifo_head[MEM_DATA_WIDTH-1:0];
            end
            if (capture) begin
                resp_write_reg <= cmd_reg_write;
                resp_rdata_reg <= capture_rdata;
            end
        end
    end

    // Requests are asserted through ISSUE and WAIT and drop once RESP is entered.
    assign pcie_read_request  = ((state == ST_ISSUE) || (state == ST_WAIT)) && !cmd_reg_write;
    assign pcie_write_request = ((state == ST_ISSUE) || (state == ST_WAIT)) &&  cmd_reg_write;
    assign pcie_read_addr     = cmd_reg_addr;
    assign pcie_write_addr    = cmd_reg_addr;
    assign pcie_write_data    = cmd_reg_wdata;

    assign resp_valid = (state == ST_RESP);
    assign resp_write = resp_write_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_pcie_mem_req_bridge.sv
// tb_pcie_mem_req_bridge
// Directed and randomized bench for pcie_mem_req_bridge. Commands are
// recorded in a queue; each response must match the oldest outstanding
// command (reads return the data the bench supplied, writes return 0).
module tb_pcie_mem_req_bridge;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_write;
    logic          resp_error;
    logic [DW-1:0] resp_rdata;
    logic          pcie_read_request;
    logic [AW-1:0] pcie_read_addr;
    logic          pcie_read_ready;
    logic [DW-1:0] pcie_read_data;
    logic          pcie_write_request;
    logic [AW-1:0] pcie_write_addr;
    logic [DW-1:0] pcie_write_data;
    logic          pcie_write_ready;

    always #5 clock = ~clock;

    pcie_mem_req_bridge #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_write         (resp_write),
        .resp_error         (resp_error),
        .resp_rdata         (resp_rdata),
        .pcie_read_request  (pcie_read_request),
        .pcie_read_addr     (pcie_read_addr),
        .pcie_read_ready    (pcie_read_ready),
        .pcie_read_data     (pcie_read_data),
        .pcie_write_request (pcie_write_request),
        .pcie_write_addr    (pcie_write_addr),
        .pcie_write_data    (pcie_write_data),
        .pcie_write_ready   (pcie_write_ready)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t pending[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        check_output("cmd_ready_before_push", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_write = $urandom_range(0, 1);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        pending.push_back(c);
    endtask

    // Act as the downstream memory for the oldest outstanding command and
    // then consume its response.
    task automatic serve(input int stall, input logic [DW-1:0] rdata, input bit wrong_pulse, input int resp_delay);
        cmd_t          c;
        int            waited;
        logic [DW-1:0] exp_rdata;
        if (pending.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL serve_no_pending observed=empty expected=command");
            return;
        end
        c = pending.pop_front();
        exp_rdata = c.write ? '0 : rdata;
        waited = 0;
        while (!(pcie_read_request || pcie_write_request) && waited < 50) begin
            tick();
            waited++;
        end
        check_output("req_seen", pcie_read_request || pcie_write_request, 1);
        check_output("req_write_kind", pcie_write_request, c.write);
        check_output("req_read_kind", pcie_read_request, !c.write);
        check_output("req_addr", c.write ? pcie_write_addr : pcie_read_addr, c.addr);
        if (c.write) check_output("req_wdata", pcie_write_data, c.wdata);
        tick();
        for (int i = 0; i < stall; i++) tick();
        check_output("req_held", c.write ? pcie_write_request : pcie_read_request, 1);
        check_output("req_addr_stable", c.write ? pcie_write_addr : pcie_read_addr, c.addr);
        check_output("no_early_resp", resp_valid, 0);
        if (wrong_pulse) begin
            if (c.write) pcie_read_ready = 1'b1;
            else         pcie_write_ready = 1'b1;
            pcie_read_data = $urandom;
            tick();
            pcie_read_ready  = 1'b0;
            pcie_write_ready = 1'b0;
            check_output("wrong_ready_ignored_req", c.write ? pcie_write_request : pcie_read_request, 1);
            check_output("wrong_ready_ignored_resp", resp_valid, 0);
        end
        if (c.write) pcie_write_ready = 1'b1;
        else         pcie_read_ready  = 1'b1;
        pcie_read_data = rdata;
        tick();
        pcie_read_ready  = 1'b0;
        pcie_write_ready = 1'b0;
        pcie_read_data   = $urandom;
        check_output("resp_valid", resp_valid, 1);
        check_output("req_dropped", pcie_read_request || pcie_write_request, 0);
        check_output("resp_write", resp_write, c.write);
        check_output("resp_rdata", resp_rdata, exp_rdata);
        check_output("resp_error", resp_error, 0);
        for (int i = 0; i < resp_delay; i++) begin
            tick();
            check_output("resp_held_valid", resp_valid, 1);
            check_output("resp_held_rdata", resp_rdata, exp_rdata);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_output("resp_consumed", resp_valid, 0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            k;
        int            high_cycles;
        reset_n            = 1'b0;
        cmd_valid          = 1'b0;
        cmd_write          = 1'b0;
        cmd_addr           = '0;
        cmd_wdata          = '0;
        resp_ready         = 1'b0;
        pcie_read_ready    = 1'b0;
        pcie_write_ready   = 1'b0;
        pcie_read_data     = '0;
        tick();
        tick();
        check_output("rst_cmd_ready", cmd_ready, 1);
        check_output("rst_resp_valid", resp_valid, 0);
        check_output("rst_read_req", pcie_read_request, 0);
        check_output("rst_write_req", pcie_write_request, 0);
        check_output("rst_resp_rdata", resp_rdata, 0);
        check_output("rst_resp_write", resp_write, 0);
        check_output("rst_resp_error", resp_error, 0);
        check_output("rst_addr", pcie_read_addr, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] single write with 5-cycle stall");
        apply_stimulus(1'b1, 16'h0010, 32'h0000_1234);
        check_output("write_req_not_yet", pcie_write_request, 0);
        tick();
        check_output("write_req_after_2", pcie_write_request, 1);
        serve(5, 32'h0, 1'b0, 2);

        $display("[TB] single read");
        apply_stimulus(1'b0, 16'h0010, 32'h0);
        serve(3, 32'h0000_1234, 1'b0, 0);

        $display("[TB] wrong-type ready during write");
        apply_stimulus(1'b1, AW'($urandom), $urandom);
        serve(2, 32'h0, 1'b1, 1);

        $display("[TB] burst of 5 with downstream stalled");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus($urandom_range(0, 1), AW'($urandom), $urandom);
        end
        check_output("burst_cmd_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("burst_still_full", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve($urandom_range(0, 3), $urandom, 1'b0, $urandom_range(0, 2));
        end
        check_output("burst_drained_ready", cmd_ready, 1);
        check_output("burst_idle_no_req", pcie_read_request || pcie_write_request, 0);

        $display("[TB] reset during WAIT");
        apply_stimulus(1'b0, AW'($urandom), 32'h0);
        tick();
        tick();
        tick();
        check_output("pre_reset_req", pcie_read_request, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_rst_read_req", pcie_read_request, 0);
        check_output("async_rst_write_req", pcie_write_request, 0);
        check_output("async_rst_resp_valid", resp_valid, 0);
        check_output("async_rst_cmd_ready", cmd_ready, 1);
        pending.delete();
        tick();
        reset_n = 1'b1;
        tick();
        apply_stimulus(1'b0, 16'hBEEF, 32'h0);
        serve(1, 32'hCAFE_F00D, 1'b0, 1);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                apply_stimulus($urandom_range(0, 1), AW'($urandom), $urandom);
            end
            for (int i = 0; i < k; i++) begin
                rd = $urandom;
                serve($urandom_range(0, 6), rd, $urandom_range(0, 1), $urandom_range(0, 3));
            end
        end

`ifdef PCIE_BRIDGE_TIMEOUT_EN
        $display("[TB] read timeout");
        apply_stimulus(1'b0, AW'($urandom), 32'h0);
        tick();
        check_output("to_req_issue", pcie_read_request, 1);
        high_cycles = 0;
        while (pcie_read_request && high_cycles < 100) begin
            tick();
            high_cycles++;
        end
        void'(pending.pop_front());
        check_output("to_req_high_cycles", high_cycles, 17);
        check_output("to_resp_valid", resp_valid, 1);
        check_output("to_resp_error", resp_error, 1);
        check_output("to_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        check_output("to_resp_write", resp_write, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_output("to_resp_consumed", resp_valid, 0);
`else
        high_cycles = 0;
        $display("[TB] long stall without timeout");
        apply_stimulus(1'b0, AW'($urandom), 32'h0);
        while (high_cycles < 40) begin
            tick();
            high_cycles++;
        end
        check_output("no_timeout_req_held", pcie_read_request, 1);
        check_output("no_timeout_no_resp", resp_valid, 0);
        serve(0, 32'h1357_9BDF, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
